// File: rtl/bp_stall_trace_pkg.sv
// Shared types for the stall trace decoder: reason encoding, record layout,
// counter map indices and decoder FSM states.
package bp_stall_trace_pkg;

   localparam int reason_width_lp = 5;

   // Same encoding and priority order as the core profiler.
   typedef enum logic [reason_width_lp-1:0] {
      e_stall_interrupt       = 5'd0,
      e_stall_exception       = 5'd1,
      e_stall_eret            = 5'd2,
      e_stall_fence           = 5'd3,
      e_stall_dcache_miss     = 5'd4,
      e_stall_long_haz        = 5'd5,
      e_stall_mem_haz         = 5'd6,
      e_stall_fma_haz         = 5'd7,
      e_stall_csr_haz         = 5'd8,
      e_stall_control_haz     = 5'd9,
      e_stall_struct_haz      = 5'd10,
      e_stall_data_haz        = 5'd11,
      e_stall_branch_override = 5'd12,
      e_stall_ret_override    = 5'd13,
      e_stall_fe_cmd_fence    = 5'd14,
      e_stall_fe_cmd          = 5'd15,
      e_stall_mispredict      = 5'd16,
      e_stall_icache_fence    = 5'd17,
      e_stall_icache_miss     = 5'd18,
      e_stall_fe_queue_stall  = 5'd19,
      e_stall_freeze          = 5'd20
   } bp_stall_reason_e;

   // Reason is kept as raw bits so out-of-range codes survive to the decoder.
   typedef struct packed {
      logic                       commit;
      logic                       stall_v;
      logic [reason_width_lp-1:0] reason;
   } bp_stall_trace_rec_s;

   localparam int commit_idx  = 21;
   localparam int unknown_idx = 22;
   localparam int total_idx   = 23;

   typedef enum logic {
      e_run   = 1'b0,
      e_clear = 1'b1
   } bp_stall_trace_state_e;

endpackage

// File: rtl/bp_stall_trace_counter.sv
// Single event counter with sweep clear. Saturates by default; wraps and flags
// a sticky overflow when BP_STALL_TRACE_OVERFLOW_EN is defined.
module bp_stall_trace_counter
  #(parameter int cnt_width_p = 32)
   (input  logic                   clk_i,
    input  logic                   reset_li,
    input  logic                   inc_i,
    input  logic                   clr_i,
    output logic [cnt_width_p-1:0] cnt_o,
    output logic                   overflow_o);

   logic [cnt_width_p-1:0] cnt_r;
   logic                   at_max;

   assign at_max = &cnt_r;
   assign cnt_o  = cnt_r;

`ifdef BP_STALL_TRACE_OVERFLOW_EN
   logic ovf_r;

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         cnt_r <= '0;
         ovf_r <= 1'b0;
      end else if (clr_i) begin
         cnt_r <= '0;
         ovf_r <= 1'b0;
      end else if (inc_i) begin
         cnt_r <= cnt_r + cnt_width_p'(1);
         if (at_max)
            ovf_r <= 1'b1;
      end
   end

   assign overflow_o = ovf_r;
`else
   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li)
         cnt_r <= '0;
      else if (clr_i)
         cnt_r <= '0;
      else if (inc_i && !at_max)
         cnt_r <= cnt_r + cnt_width_p'(1);
   end

   assign overflow_o = 1'b0;
`endif

endmodule

// File: rtl/bp_stall_trace_decoder.sv
// Per-cycle stall trace consumer: histogram counters, read port and sweep clear.
// Optional wrap/overflow counters: BP_STALL_TRACE_OVERFLOW_EN.
//
// state   | meaning
// e_run   | records and reads accepted
// e_clear | sweep zeroes one counter per cycle, entry 0..23; ports stalled
module bp_stall_trace_decoder
   import bp_stall_trace_pkg::*;
  #(parameter int num_reasons_p  = 21,
    parameter int reason_width_p = 5,
    parameter int cnt_width_p    = 32,
    localparam int num_entries_lp = num_reasons_p + 3)
   (input  logic                      clk_i,
    input  logic                      reset_li,
    input  logic                      rec_v_i,
    output logic                      rec_ready_o,
    input  logic                      rec_commit_i,
    input  logic                      rec_stall_v_i,
    input  logic [reason_width_p-1:0] rec_reason_i,
    input  logic                      clear_i,
    output logic                      busy_o,
    input  logic                      rd_v_i,
    output logic                      rd_ready_o,
    input  logic [4:0]                rd_addr_i,
    output logic                      rd_v_o,
    output logic [cnt_width_p-1:0]    rd_data_o,
    input  logic                      rd_yumi_i,
    output logic [num_entries_lp-1:0] overflow_o);

   bp_stall_trace_state_e state_r, state_n;
   logic [4:0]            sweep_r, sweep_n;

   bp_stall_trace_rec_s       rec;
   logic                      rec_accept;
   logic                      reason_in_range;
   logic [num_entries_lp-1:0] inc_vec;
   logic [num_entries_lp-1:0] clr_vec;
   logic [cnt_width_p-1:0]    cnt [num_entries_lp];

   logic                   rd_accept;
   logic                   rd_v_r;
   logic [cnt_width_p-1:0] rd_data_r;
   logic [cnt_width_p-1:0] rd_sel;

   assign rec = '{commit: rec_commit_i, stall_v: rec_stall_v_i, reason: rec_reason_i};

   assign busy_o      = (state_r == e_clear);
   assign rec_ready_o = (state_r == e_run) && !clear_i;
   assign rd_ready_o  = (state_r == e_run) && !clear_i && !rd_v_r;
   assign rec_accept  = rec_v_i && rec_ready_o;
   assign rd_accept   = rd_v_i && rd_ready_o;
   assign rd_v_o      = rd_v_r;
   assign rd_data_o   = rd_data_r;

   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         state_r <= e_run;
         sweep_r <= '0;
      end else begin
         state_r <= state_n;
         sweep_r <= sweep_n;
      end
   end

   always_comb begin
      state_n = state_r;
      sweep_n = sweep_r;
      clr_vec = '0;
      case (state_r)
         e_run: begin
            if (clear_i) begin
               state_n = e_clear;
               sweep_n = '0;
            end
         end
         e_clear: begin
            for (int i = 0; i < num_entries_lp; i++)
               clr_vec[i] = (sweep_r == 5'(i));
            sweep_n = sweep_r + 5'd1;
            if (sweep_r == 5'(total_idx)) begin
               state_n = e_run;
               sweep_n = '0;
            end
         end
         default: state_n = e_run;
      endcase
   end

   assign reason_in_range = (rec.reason < reason_width_lp'(num_reasons_p));

   // Exactly one class counter plus the total counter per accepted record.
   always_comb begin
      inc_vec = '0;
      if (rec_accept) begin
         inc_vec[total_idx] = 1'b1;
         if (rec.commit)
            inc_vec[commit_idx] = 1'b1;
         else if (rec.stall_v && reason_in_range) begin
            for (int i = 0; i < num_reasons_p; i++)
               inc_vec[i] = (rec.reason == reason_width_lp'(i));
         end else
            inc_vec[unknown_idx] = 1'b1;
      end
   end

   for (genvar g = 0; g < num_entries_lp; g++) begin : g_cnt
      bp_stall_trace_counter #(.cnt_width_p(cnt_width_p)) counter
        (.clk_i      (clk_i),
         .reset_li   (reset_li),
         .inc_i      (inc_vec[g]),
         .clr_i      (clr_vec[g]),
         .cnt_o      (cnt[g]),
         .overflow_o (overflow_o[g]));
   end

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < num_entries_lp; i++)
         if (rd_addr_i == 5'(i))
            rd_sel = cnt[i];
   end

   // Reads sample registered counts, so a same-cycle increment is not visible.
   always_ff @(posedge clk_i or negedge reset_li) begin
      if (!reset_li) begin
         rd_v_r    <= 1'b0;
         rd_data_r <= '0;
      end else if (state_r == e_run && clear_i) begin
         rd_v_r <= 1'b0;
      end else if (rd_accept) begin
         rd_v_r    <= 1'b1;
         rd_data_r <= rd_sel;
      end else if (rd_yumi_i) begin
         rd_v_r <= 1'b0;
      end
   end

endmodule

// File: doc/bp_stall_trace_decoder.md
Name: bp_stall_trace_decoder

Overview:
Consumer side of the per-cycle core stall trace. Accepts one record per retired cycle: commit, encoded stall reason, or unknown. Decodes the 5-bit reason code into per-reason event counters, plus commit, unknown and total-cycle counters. Exposes a valid/ready read port and a sweep-clear sequence so a debug host or testbench can sample stall histograms without parsing a trace file.

Parameters:
num_reasons_p, 21, number of stall reason codes (0..20, priority order: code 0 = _interrupt ... code 20 = freeze)
reason_width_p, 5, width of encoded reason field
cnt_width_p, 32, width of each counter
num_entries_lp, num_reasons_p+3, counter entries; derived, not overridable

Ports:
clk_i  in  1  clock
reset_li  in  1  reset
rec_v_i  in  1  trace record valid
rec_ready_o  out  1  decoder can accept a record
rec_commit_i  in  1  record is an instruction commit
rec_stall_v_i  in  1  reason field valid
rec_reason_i  in  reason_width_p  encoded stall reason
clear_i  in  1  request clear of all counters; one-cycle pulse
busy_o  out  1  clear sweep in progress
rd_v_i  in  1  read request valid
rd_ready_o  out  1  read request accepted when high
rd_addr_i  in  5  counter index
rd_v_o  out  1  read response valid
rd_data_o  out  cnt_width_p  counter value
rd_yumi_i  in  1  response consumed
overflow_o  out  num_entries_lp  per-counter sticky overflow (see Optional Feature)

Behaviour:
- Reset: reset_li, asynchronous, active-low; clock clk_i. Reset state: all counters 0, FSM e_run, busy_o=0, rd_v_o=0, rd_data_o=0, overflow_o=0, rec_ready_o=1, rd_ready_o=1.
- Counter map: index 0..20 = reason code; 21 = commit; 22 = unknown; 23 = total accepted records. Read of an index above 23 returns 0.
- Record accept: rec_v_i & rec_ready_o. Accepted records update counters on the next clk_i edge.
  - rec_commit_i=1: commit counter +1. Reason field is ignored, even if rec_stall_v_i=1.
  - Else if rec_stall_v_i=1 and rec_reason_i<num_reasons_p: counter[rec_reason_i] +1.
  - Else, including an out-of-range code: unknown counter +1.
  - Total counter +1 on every accepted record. Exactly one class counter plus the total counter increments per record.
- FSM states:
  - e_run: records and reads accepted.
  - e_clear: sweep pointer zeroes one entry per cycle, index 0 up to 23. Takes 24 cycles. rec_ready_o=0, rd_ready_o=0, busy_o=1. Returns to e_run after entry 23.
  - e_run -> e_clear on clear_i. A clear_i pulse during e_clear is ignored. A record presented in the same cycle as clear_i is not accepted (rec_ready_o is combinationally low when clear_i=1).
- Read port:
  - Accepted read samples the addressed counter's registered value. Value appears on rd_data_o with rd_v_o=1 one cycle later.
  - Response is held stable until rd_yumi_i. rd_ready_o=0 while a response is pending.
  - A simultaneous record update to the same entry is not visible; the read returns the pre-increment value.
  - Record acceptance continues while a response is pending.
  - rd_v_o is forced 0 on entry to e_clear; any pending response is dropped.
- Default counter arithmetic: saturate at 2^cnt_width_p-1. overflow_o stays 0.
- Reset asserted mid-clear or mid-read: immediate return to reset state.

Optional Feature:
BP_STALL_TRACE_OVERFLOW_EN
- Defined: counters wrap modulo 2^cnt_width_p. overflow_o[i] sets on the wrap of counter i and clears only on reset or when the sweep reaches entry i.
- Undefined: counters saturate and overflow_o is tied 0.

Decomposition:
- Package bp_stall_trace_pkg: bp_stall_reason_e (codes 0..20, identical encoding to the profiler), record struct bp_stall_trace_rec_s {commit, stall_v, reason}, index localparams commit_idx=21, unknown_idx=22, total_idx=23, and FSM enum.
- Sub-module bp_stall_trace_counter: one cnt_width_p counter with inc_i, clr_i and the overflow/saturate logic; instantiated num_entries_lp times.

Test Plan:
- Reset release, then 10 records each with reason=4 (dcache_miss) -> read idx 4 = 10; idx 23 = 10; idx 21 = 0.
- Record with commit=1, stall_v=1, reason=20 -> idx 21 = 1; idx 20 = 0.
- Record with reason=25, stall_v=1, then one with stall_v=0 -> idx 22 = 2.
- clear_i while counters are nonzero -> busy_o high for exactly 24 cycles and rec_ready_o low throughout; afterwards reads of idx 0..23 all return 0.
- Read idx 4 (value 10) in the same cycle a reason=4 record is accepted -> rd_data_o=10. Hold rd_yumi_i low 3 cycles: data stable and rd_ready_o=0. Next read returns 11.
- cnt_width_p=4, 17 commits -> without macro idx 21 = 15 and overflow_o=0; with BP_STALL_TRACE_OVERFLOW_EN idx 21 = 1 and overflow_o[21]=1.
